// File: rtl/button_debounce_multi.sv
`default_nettype none
// ============================================================================
//  Module      : button_debounce_multi
//  Description : N-channel push-button debouncer. Each channel has a 2-flop
//                synchroniser, a debounce counter and a hold timer, and
//                produces a stable level, press/release pulses and a
//                long-press pulse. An optional auto-repeat pulse train follows
//                the long-press pulse while the button stays held.
//  Optional    : define BUTTON_AUTOREPEAT_EN to build the auto-repeat logic;
//                otherwise btn_repeat is tied to 0.
//  Ports       : clk          system clock
//                rst          synchronous active-high reset
//                btn_raw      [N_CH] asynchronous raw inputs, 1 = pressed
//                btn_level    [N_CH] debounced stable level
//                btn_press    [N_CH] one-cycle pulse on accepted 0->1
//                btn_release  [N_CH] one-cycle pulse on accepted 1->0
//                btn_long     [N_CH] one-cycle pulse after HOLD_CYCLES held
//                btn_repeat   [N_CH] auto-repeat pulses (0 when not built)
//  Revision    : 1.0  initial release
// ============================================================================
module button_debounce_multi #(
  parameter int N_CH          = 4,
  parameter int DEB_CYCLES    = 100000,
  parameter int HOLD_CYCLES   = 10000000,
  parameter int REPEAT_CYCLES = 2000000,
  parameter int CNT_W         = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_raw,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_press,
  output logic [N_CH-1:0] btn_release,
  output logic [N_CH-1:0] btn_long,
  output logic [N_CH-1:0] btn_repeat
);

  // Hold-timing states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_LONG = 2'd2;

  // Terminal counts: a counter reaching its LAST value completes on the next edge
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  // Reject configurations the counters cannot honour
  if (DEB_CYCLES < 2 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_param_err
    $error("button_debounce_multi: DEB_CYCLES>=2, HOLD_CYCLES>=1, REPEAT_CYCLES>=1 required");
  end

  // --------------------------------------------------------------------------
  // Two-flop synchroniser, all channels
  // --------------------------------------------------------------------------
  logic [N_CH-1:0] sync1_q, sync1_d;
  logic [N_CH-1:0] sync2_q, sync2_d;

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

`ifndef BUTTON_AUTOREPEAT_EN
  assign btn_repeat = '0;
`endif

  // --------------------------------------------------------------------------
  // Per-channel debounce and hold timing
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic             s2;
    logic [CNT_W-1:0] deb_cnt_q,  deb_cnt_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [1:0]       state_q,    state_d;
    logic             level_q,    level_d;
    logic             press_q,    press_d;
    logic             release_q,  release_d;
    logic             long_q,     long_d;
`ifdef BUTTON_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
    logic [CNT_W-1:0] rep_cnt_q,  rep_cnt_d;
    logic             repeat_q,   repeat_d;
`endif

    assign s2 = sync2_q[i];

    always_comb begin
      deb_cnt_d  = deb_cnt_q;
      hold_cnt_d = hold_cnt_q;
      state_d    = state_q;
      level_d    = level_q;
      press_d    = 1'b0;
      release_d  = 1'b0;
      long_d     = 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
      rep_cnt_d  = rep_cnt_q;
      repeat_d   = 1'b0;
`endif

      // Debounce: a differing s2 must persist DEB_CYCLES edges to be accepted;
      // any sample matching the current level restarts the count.
      if (s2 == level_q) begin
        deb_cnt_d = CNT_ZERO;
      end else if (deb_cnt_q == DEB_LAST) begin
        deb_cnt_d = CNT_ZERO;
        level_d   = s2;
        press_d   = s2;
        release_d = ~s2;
      end else begin
        deb_cnt_d = deb_cnt_q + CNT_ONE;
      end

      // Hold timing; an accepted release takes priority over every timer.
      case (state_q)
        ST_IDLE: begin
          if (press_d) begin
            state_d    = ST_HOLD;
            hold_cnt_d = CNT_ZERO;
          end
        end
        ST_HOLD: begin
          if (release_d) begin
            state_d    = ST_IDLE;
            hold_cnt_d = CNT_ZERO;
          end else if (hold_cnt_q == HOLD_LAST) begin
            state_d    = ST_LONG;
            hold_cnt_d = CNT_ZERO;
            long_d     = 1'b1;
          end else begin
            hold_cnt_d = hold_cnt_q + CNT_ONE;
          end
        end
        ST_LONG: begin
          if (release_d) begin
            state_d    = ST_IDLE;
            hold_cnt_d = CNT_ZERO;
`ifdef BUTTON_AUTOREPEAT_EN
            rep_cnt_d  = CNT_ZERO;
`endif
          end
`ifdef BUTTON_AUTOREPEAT_EN
          else if (rep_cnt_q == REP_LAST) begin
            rep_cnt_d = CNT_ZERO;
            repeat_d  = 1'b1;
          end else begin
            rep_cnt_d = rep_cnt_q + CNT_ONE;
          end
`endif
        end
        default: begin
          state_d    = ST_IDLE;
          hold_cnt_d = CNT_ZERO;
        end
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        deb_cnt_q  <= CNT_ZERO;
        hold_cnt_q <= CNT_ZERO;
        state_q    <= ST_IDLE;
        level_q    <= 1'b0;
        press_q    <= 1'b0;
        release_q  <= 1'b0;
        long_q     <= 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
        rep_cnt_q  <= CNT_ZERO;
        repeat_q   <= 1'b0;
`endif
      end else begin
        deb_cnt_q  <= deb_cnt_d;
        hold_cnt_q <= hold_cnt_d;
        state_q    <= state_d;
        level_q    <= level_d;
        press_q    <= press_d;
        release_q  <= release_d;
        long_q     <= long_d;
`ifdef BUTTON_AUTOREPEAT_EN
        rep_cnt_q  <= rep_cnt_d;
        repeat_q   <= repeat_d;
`endif
      end
    end

    assign btn_level[i]   = level_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = release_q;
    assign btn_long[i]    = long_q;
`ifdef BUTTON_AUTOREPEAT_EN
    assign btn_repeat[i]  = repeat_q;
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_button_debounce_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_debounce_multi
//  Description : Self-checking bench for button_debounce_multi with N_CH=2,
//                DEB_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3. Stimulus
//                pushes expected pulse events (keyed by edge number) into a
//                sorted queue; a monitor pops them after every edge and
//                compares all outputs. Cycles with no queued event must show
//                no pulses. Define BUTTON_AUTOREPEAT_EN to expect repeats.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_button_debounce_multi;

  localparam int N_CH = 2;
  localparam int DEB  = 4;
  localparam int HOLD = 10;
  localparam int REP  = 3;

  localparam int K_PRESS = 0;
  localparam int K_REL   = 1;
  localparam int K_LONG  = 2;
  localparam int K_REP   = 3;
  localparam int K_CLR   = 4;

  logic            clk;
  logic            rst;
  logic [N_CH-1:0] btn_raw;
  logic [N_CH-1:0] btn_level;
  logic [N_CH-1:0] btn_press;
  logic [N_CH-1:0] btn_release;
  logic [N_CH-1:0] btn_long;
  logic [N_CH-1:0] btn_repeat;

  button_debounce_multi #(
    .N_CH(N_CH), .DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD),
    .REPEAT_CYCLES(REP), .CNT_W(32)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
    .btn_long(btn_long), .btn_repeat(btn_repeat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int              cyc;
    logic [N_CH-1:0] press;
    logic [N_CH-1:0] rel;
    logic [N_CH-1:0] lng;
    logic [N_CH-1:0] rep;
    bit              clr;
  } exp_t;

  exp_t            exp_q[$];
  exp_t            mon_e;
  logic [N_CH-1:0] exp_level;
  int              cyc;
  int              n_checks;
  int              n_pass;

  initial begin
    cyc       = 0;
    n_checks  = 0;
    n_pass    = 0;
    exp_level = '0;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at edge %0d: got %0h expected %0h", tag, cyc, got, exp);
  endtask

  // Insert an expected event, keeping the queue sorted by edge number and
  // merging events that fall on the same edge.
  task automatic add_exp(input int c, input int kind, input int ch);
    int   idx;
    exp_t e;
    idx = exp_q.size();
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i].cyc >= c) begin
        idx = i;
        break;
      end
    end
    if (idx < exp_q.size() && exp_q[idx].cyc == c) begin
      e = exp_q[idx];
    end else begin
      e = '{cyc: c, press: '0, rel: '0, lng: '0, rep: '0, clr: 1'b0};
      exp_q.insert(idx, e);
    end
    case (kind)
      K_PRESS: e.press[ch] = 1'b1;
      K_REL:   e.rel[ch]   = 1'b1;
      K_LONG:  e.lng[ch]   = 1'b1;
      K_REP:   e.rep[ch]   = 1'b1;
      default: e.clr       = 1'b1;
    endcase
    exp_q[idx] = e;
  endtask

  // Repeat pulses expected from first_cyc in steps of REP, strictly before end_cyc
  task automatic add_reps(input int first_cyc, input int end_cyc, input int ch);
`ifdef BUTTON_AUTOREPEAT_EN
    for (int k = first_cyc; k < end_cyc; k += REP) add_exp(k, K_REP, ch);
`else
    if (first_cyc > end_cyc && ch < 0) add_exp(0, K_REP, 0);
`endif
  endtask

  // Monitor: sample 1 time unit after every active edge
  always @(posedge clk) begin
    #1;
    mon_e = '{cyc: cyc, press: '0, rel: '0, lng: '0, rep: '0, clr: 1'b0};
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) mon_e = exp_q.pop_front();
    if (mon_e.clr) exp_level = '0;
    exp_level = (exp_level | mon_e.press) & ~mon_e.rel;
    check_val("level",   32'(btn_level),   32'(exp_level));
    check_val("press",   32'(btn_press),   32'(mon_e.press));
    check_val("release", 32'(btn_release), 32'(mon_e.rel));
    check_val("long",    32'(btn_long),    32'(mon_e.lng));
    check_val("repeat",  32'(btn_repeat),  32'(mon_e.rep));
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int c;
    rst     = 1'b1;
    btn_raw = '0;
    idle(2);
    rst = 1'b0;
    idle(3);

    // Clean press on ch0, 3-cycle dropout (no release), then a release that
    // is accepted on the very edge the hold timer would complete.
    c = cyc;
    btn_raw[0] = 1'b1;
    add_exp(c + 2 + DEB, K_PRESS, 0);
    idle(6);
    btn_raw[0] = 1'b0;
    idle(3);
    btn_raw[0] = 1'b1;
    idle(1);
    btn_raw[0] = 1'b0;
    add_exp(c + 16, K_REL, 0);
    idle(10);

    // Bounce 1,0,1,0 then stable 1 on ch0, followed by a short release
    c = cyc;
    btn_raw[0] = 1'b1; idle(1);
    btn_raw[0] = 1'b0; idle(1);
    btn_raw[0] = 1'b1; idle(1);
    btn_raw[0] = 1'b0; idle(1);
    btn_raw[0] = 1'b1;
    add_exp(c + 4 + 2 + DEB, K_PRESS, 0);
    idle(7);
    btn_raw[0] = 1'b0;
    add_exp(c + 11 + 2 + DEB, K_REL, 0);
    idle(10);

    // Long press on ch1
    c = cyc;
    btn_raw[1] = 1'b1;
    add_exp(c + 6, K_PRESS, 1);
    add_exp(c + 6 + HOLD, K_LONG, 1);
    add_reps(c + 6 + HOLD + REP, c + 32, 1);
    idle(26);
    btn_raw[1] = 1'b0;
    add_exp(c + 32, K_REL, 1);
    idle(10);

    // Simultaneous press on both channels, ch0 released alone
    c = cyc;
    btn_raw = 2'b11;
    add_exp(c + 6, K_PRESS, 0);
    add_exp(c + 6, K_PRESS, 1);
    idle(7);
    btn_raw = 2'b10;
    add_exp(c + 13, K_REL, 0);
    add_exp(c + 16, K_LONG, 1);
    add_reps(c + 19, c + 26, 1);
    idle(13);
    btn_raw = 2'b00;
    add_exp(c + 26, K_REL, 1);
    idle(10);

    // Synchronous reset at press+5 while ch1 stays held
    c = cyc;
    btn_raw = 2'b10;
    add_exp(c + 6, K_PRESS, 1);
    idle(10);
    rst = 1'b1;
    add_exp(c + 11, K_CLR, 0);
    idle(1);
    rst = 1'b0;
    add_exp(c + 17, K_PRESS, 1);
    add_exp(c + 27, K_LONG, 1);
    add_reps(c + 30, c + 34, 1);
    idle(17);
    btn_raw = 2'b00;
    add_exp(c + 34, K_REL, 1);
    idle(10);

    check_val("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
